iob_timer_dn: RTL and testbench

- Loadable down-counting timer with prescaler.
- Counts a loaded value down to zero, then emits a one-cycle expire pulse. In periodic mode it then reloads; in one-shot mode it stops.
- A sticky pending/overrun pair, cleared by an acknowledge, lets a slow consumer detect expiries it missed.
- Used as the countdown counterpart to the loadable up-counters in timers, watchdogs and timeout logic.

---
 rtl/iob_timer_dn.sv | 88 ++++++++
 tb/tb_iob_timer_dn.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/iob_timer_dn.sv
// iob_timer_dn: loadable prescaled down-counter with expire pulse and sticky pending/overrun flags
module iob_timer_dn #(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ce_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               periodic_i,
    input  logic [DATA_W-1:0]  ld_val_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               ack_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               busy_o,
    output logic               expire_o,
    output logic               pend_o,
    output logic               ovr_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic mode_q, mode_d, expire_q, expire_d, pend_q, pend_d, ovr_q, ovr_d;
    logic tick, term;
    always_comb begin
        tick = (state_q == RUN) && (pcnt_q == presc_q);
        term = tick && (cnt_q == '0) && !start_i && !stop_i;
        state_d = state_q;
        cnt_d = cnt_q;
        reload_d = reload_q;
        presc_d = presc_q;
        pcnt_d = pcnt_q;
        mode_d = mode_q;
        expire_d = term;
        // an ack coinciding with a terminal tick only retires earlier events
        pend_d = term | (pend_q & ~ack_i);
        ovr_d = ~ack_i & (ovr_q | (term & pend_q));
        if (start_i) begin
            state_d = RUN;
            cnt_d = ld_val_i;
            reload_d = ld_val_i;
            presc_d = presc_i;
            mode_d = periodic_i;
            pcnt_d = '0;
        end else if (stop_i) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
            if (tick) begin
                if (cnt_q != '0) cnt_d = cnt_q - DATA_W'(1);
                else if (mode_q) cnt_d = reload_q;
                else state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            reload_q <= '0;
            presc_q <= '0;
            pcnt_q <= '0;
            mode_q <= 1'b0;
            expire_q <= 1'b0;
            pend_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (ce_i) begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            reload_q <= reload_d;
            presc_q <= presc_d;
            pcnt_q <= pcnt_d;
            mode_q <= mode_d;
            expire_q <= expire_d;
            pend_q <= pend_d;
            ovr_q <= ovr_d;
        end else begin
            expire_q <= 1'b0;
        end
    end
    assign data_o = cnt_q;
    assign busy_o = (state_q == RUN);
    assign expire_o = expire_q;
    assign pend_o = pend_q;
    assign ovr_o = ovr_q;
endmodule

// File: tb/tb_iob_timer_dn.sv
// tb_iob_timer_dn: directed scenario tasks for iob_timer_dn with inline expected values
module tb_iob_timer_dn;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        periodic = 1'b0;
    logic [31:0] ld_val = '0;
    logic [7:0]  presc = '0;
    logic        ack = 1'b0;
    logic [31:0] data;
    logic        busy, expire, pend, ovr;
    int n_cmp = 0;
    int n_bad = 0;

    iob_timer_dn #(.DATA_W(32), .PRESC_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .start_i(start), .stop_i(stop),
        .periodic_i(periodic), .ld_val_i(ld_val), .presc_i(presc), .ack_i(ack),
        .data_o(data), .busy_o(busy), .expire_o(expire), .pend_o(pend), .ovr_o(ovr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; start = 1'b1; ld_val = 32'd9;
        cyc(); cyc();
        start = 1'b0;
        n_cmp++; if (data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (expire !== 1'b0) begin n_bad++; $display("FAIL reset_expire got %b want 0", expire); end
        n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL reset_pend got %b want 0", pend); end
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", ovr); end
        rst_n = 1'b1; ce = 1'b1;
    endtask

    task automatic test_oneshot();
        ld_val = 32'd3; presc = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (data !== 32'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL os_load data=%0d busy=%b want 3/1", data, busy); end
        for (int i = 1; i <= 5; i++) begin
            cyc();
            n_cmp++; if (data !== ((i >= 3) ? 32'd0 : 32'(3 - i))) begin n_bad++; $display("FAIL os_data[%0d] got %0d", i, data); end
            n_cmp++; if (expire !== (i == 4)) begin n_bad++; $display("FAIL os_expire[%0d] got %b want %b", i, expire, i == 4); end
            n_cmp++; if (busy !== (i < 4)) begin n_bad++; $display("FAIL os_busy[%0d] got %b want %b", i, busy, i < 4); end
        end
        n_cmp++; if (pend !== 1'b1 || ovr !== 1'b0) begin n_bad++; $display("FAIL os_flags pend=%b ovr=%b want 1/0", pend, ovr); end
        ack = 1'b1; cyc(); ack = 1'b0;
        n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL os_ack pend=%b want 0", pend); end
    endtask

    task automatic test_periodic();
        ld_val = 32'd2; presc = 8'd1; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            n_cmp++; if (expire !== (i % 6 == 0)) begin n_bad++; $display("FAIL per_expire[%0d] got %b want %b", i, expire, i % 6 == 0); end
            n_cmp++; if (data !== 32'(2 - (i % 6) / 2)) begin n_bad++; $display("FAIL per_data[%0d] got %0d want %0d", i, data, 2 - (i % 6) / 2); end
            if (i == 6) begin
                n_cmp++; if (pend !== 1'b1 || ovr !== 1'b0) begin n_bad++; $display("FAIL per_first pend=%b ovr=%b want 1/0", pend, ovr); end
            end
            if (i == 12) begin
                n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL per_ovr got %b want 1", ovr); end
            end
        end
        ack = 1'b1; cyc(); ack = 1'b0;
        n_cmp++; if (pend !== 1'b0 || ovr !== 1'b0) begin n_bad++; $display("FAIL per_ack pend=%b ovr=%b want 0/0", pend, ovr); end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_n0_p0();
        ld_val = 32'd0; presc = 8'd0; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (expire !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL n0_start expire=%b busy=%b want 0/1", expire, busy); end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_cmp++; if (expire !== 1'b1) begin n_bad++; $display("FAIL n0_expire[%0d] got %b want 1", i, expire); end
            if (i == 1) begin
                n_cmp++; if (pend !== 1'b1 || ovr !== 1'b0) begin n_bad++; $display("FAIL n0_first pend=%b ovr=%b want 1/0", pend, ovr); end
            end
            if (i == 2) begin
                n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL n0_ovr got %b want 1", ovr); end
            end
        end
        ack = 1'b1; cyc(); ack = 1'b0;
        n_cmp++; if (pend !== 1'b1 || ovr !== 1'b0 || expire !== 1'b1) begin n_bad++; $display("FAIL n0_ack_on_expire pend=%b ovr=%b exp=%b want 1/0/1", pend, ovr, expire); end
        stop = 1'b1; cyc(); stop = 1'b0;
        n_cmp++; if (expire !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL n0_stop expire=%b busy=%b want 0/0", expire, busy); end
    endtask

    task automatic test_stop_restart();
        ack = 1'b1; cyc(); ack = 1'b0;
        ld_val = 32'd10; presc = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        n_cmp++; if (data !== 32'd5) begin n_bad++; $display("FAIL sr_count got %0d want 5", data); end
        stop = 1'b1; cyc(); stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || data !== 32'd5 || expire !== 1'b0) begin n_bad++; $display("FAIL sr_stop busy=%b data=%0d exp=%b want 0/5/0", busy, data, expire); end
        repeat (3) cyc();
        n_cmp++; if (data !== 32'd5 || pend !== 1'b0) begin n_bad++; $display("FAIL sr_hold data=%0d pend=%b want 5/0", data, pend); end
        ld_val = 32'd7; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (busy !== 1'b1 || data !== 32'd7) begin n_bad++; $display("FAIL sr_start_wins busy=%b data=%0d want 1/7", busy, data); end
        cyc();
        n_cmp++; if (data !== 32'd6) begin n_bad++; $display("FAIL sr_resume got %0d want 6", data); end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_gating();
        int en;
        ld_val = 32'd4; presc = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        en = 0;
        for (int i = 0; i < 12; i++) begin
            ce = (i % 2 == 1);
            start = 1'b1;
            ld_val = 32'd99;
            if (ce) begin start = 1'b0; ld_val = 32'd4; end
            cyc();
            if (ce) en++;
            n_cmp++; if (data !== ((en >= 4) ? 32'd0 : 32'(4 - en))) begin n_bad++; $display("FAIL gate_data[%0d] got %0d en=%0d", i, data, en); end
            n_cmp++; if (expire !== (ce && en == 5)) begin n_bad++; $display("FAIL gate_expire[%0d] got %b want %b", i, expire, ce && en == 5); end
            n_cmp++; if (busy !== (en < 5)) begin n_bad++; $display("FAIL gate_busy[%0d] got %b want %b", i, busy, en < 5); end
        end
        start = 1'b0; ce = 1'b1;
    endtask

    task automatic test_abort();
        ld_val = 32'd10; presc = 8'd0; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        n_cmp++; if (busy !== 1'b1 || data !== 32'd8) begin n_bad++; $display("FAIL abort_pre busy=%b data=%0d want 1/8", busy, data); end
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0 || data !== 32'd0 || expire !== 1'b0 || pend !== 1'b0 || ovr !== 1'b0) begin
            n_bad++; $display("FAIL abort_rst busy=%b data=%0d exp=%b pend=%b ovr=%b want all 0", busy, data, expire, pend, ovr);
        end
        repeat (3) cyc();
        n_cmp++; if (busy !== 1'b0 || data !== 32'd0) begin n_bad++; $display("FAIL abort_idle busy=%b data=%0d want 0/0", busy, data); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_n0_p0();
        test_stop_restart();
        test_gating();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
